op_serializer: RTL and testbench
================================

# op_serializer

Transmit-side counterpart of the op builder: accepts one complete `Op_st` over a valid/ready handshake and replays it as the field-by-field write sequence the builder consumes. The sequence is zero, then cmd+flags, then arg_1..arg_4. It sits between any op source (host link, op FIFO, test stimulus) and the builder's `zero`/`cmd`/`arg`/`flags`/`set_*` inputs. It shares the builder's clock and `clk_en` so that every strobe is consumed exactly once.

## Interface
Parameters: none. Widths come from `OP_CMD_BITS`, `OP_ARG_BITS` and `OP_FLAGS_BITS` in `common/common.svh`.

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `clk_en`  in  1  advance enable; when low, all state and outputs hold
- `op_in`  in  Op_st  op to send; sampled on accept
- `in_valid`  in  1  source has an op
- `in_ready`  out  1  block is idle and can accept
- `zero`  out  1  clear strobe to the builder
- `cmd`  out  `OP_CMD_BITS`  latched `op.cmd`
- `arg`  out  `OP_ARG_BITS`  argument for the current arg strobe
- `flags`  out  `OP_FLAGS_BITS`  latched `op.flags`
- `set_cmd`, `set_flags`  out  1 each  header strobes
- `set_arg_1`..`set_arg_4`  out  1 each  argument strobes
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle pulse after the final strobe

## Operation
- State machine states: IDLE, ZERO, HDR, A1, A2, A3, A4.
- Outputs are Moore-decoded from registered state and from the latched op. No output depends combinationally on `in_valid` or `op_in`.
- Accept:
  - Happens when `in_valid && in_ready && clk_en` is true at a rising edge.
  - On accept, `op_in` is latched whole and the state goes IDLE→ZERO.
  - `in_ready` = (state == IDLE).
- Strobe decode (all strobes 0 in every other state):
  - ZERO: `zero`=1.
  - HDR: `set_cmd`=`set_flags`=1.
  - A*n*: `set_arg_n`=1 and `arg` = latched `arg_n`.
- `arg` value in non-A states: 0.
- `cmd` and `flags` always show the latched values.
- Transitions on each `clk_en` edge: ZERO→HDR→A1→A2→A3→A4→IDLE.
- `busy` = (state != IDLE).
- `done` is registered. It goes high on the edge where the state returns to IDLE and lasts exactly one `clk_en` cycle.
- Only one field strobe group is ever active in a cycle. `zero` is never asserted with any `set_*`.
- `op_in` changes while busy are ignored, because the latched copy is used.
- Reset, including in the middle of a sequence:
  - Next edge gives state IDLE, latched op all-zero, all strobes 0.
  - `cmd`/`arg`/`flags` = 0, `busy`=0, `done`=0, `in_ready`=1.
  - A partially written op is abandoned. No completing `done` is issued.
- `clk_en` low:
  - State, latched op and `done` hold.
  - Strobes stay asserted but are not consumed, since the builder gates on the same `clk_en`.

## Timing
- Let edge E be the accept edge.
- `zero` is visible in cycle E+1. `set_cmd`/`set_flags` in E+2. `set_arg_1..4` in E+3..E+6.
- `done` is high in E+7 (all counts with `clk_en`=1).
- Throughput is 1 op per 7 cycles. The next accept is possible at edge E+7, because `in_ready`=1 in cycle E+7.
- Each cycle with `clk_en`=0 stretches the sequence by one cycle at the point where it occurs.

## Configuration
- Macro `OP_SERIALIZER_SKIP_ZERO_ARGS_EN`.
- When defined:
  - After HDR and after each A*n*, the next state is the lowest-numbered remaining A*k* whose latched `arg_k` != 0. If there is none, the next state is IDLE.
  - A skipped argument relies on the preceding `zero` clear.
  - Latency becomes 3 + (number of nonzero args) cycles to `done`.
  - An all-zero-arg op gives `done` at E+3.
- When undefined: all four arg strobes are always issued. Timing is fixed as above.

## Test plan
- Reset held 2 cycles, then released:
  - All strobes 0, `cmd`/`arg`/`flags` 0, `in_ready`=1, `busy`=0, `done`=0.
- Accept {G03, 1, 2, 3, 4, flags 3}:
  - `zero` at E+1.
  - `set_cmd`+`set_flags` with cmd=G03, flags=3 at E+2.
  - arg=1,2,3,4 with `set_arg_1..4` at E+3..E+6.
  - `done` at E+7.
  - A connected op builder then holds {G03,1,2,3,4,3}.
- Back-to-back with `in_valid` held high, second op {G01,5,5,0,0,0}:
  - Second accept happens at edge E+7.
  - Second `zero` at E+8.
  - `in_ready`=0 in E+1..E+6.
- `clk_en` low for 3 cycles during A2:
  - `set_arg_2` and arg=2 held for 4 cycles.
  - `done` delayed to E+10.
- Reset asserted in HDR:
  - Next cycle has all outputs at reset values, `in_ready`=1 and no `done`.
  - A new op is accepted normally afterwards.
- With `OP_SERIALIZER_SKIP_ZERO_ARGS_EN` defined, op {G01,0,7,0,0,0}:
  - `zero` at E+1, HDR at E+2.
  - `set_arg_2` with arg=7 at E+3.
  - `done` at E+4.
  - `set_arg_1`/`set_arg_3`/`set_arg_4` never asserted.

Source files
------------

// File: rtl/op_serializer.sv
// Replays one latched Op_st as the builder's field-write sequence: zero, cmd+flags, arg_1..arg_4.
// Optional OP_SERIALIZER_SKIP_ZERO_ARGS_EN drops strobes for args that are zero.

package op_serializer_pkg;
   localparam int OP_CMD_BITS   = 8;
   localparam int OP_ARG_BITS   = 16;
   localparam int OP_FLAGS_BITS = 4;

   typedef struct packed {
      logic [OP_CMD_BITS-1:0]   cmd;
      logic [OP_ARG_BITS-1:0]   arg_1;
      logic [OP_ARG_BITS-1:0]   arg_2;
      logic [OP_ARG_BITS-1:0]   arg_3;
      logic [OP_ARG_BITS-1:0]   arg_4;
      logic [OP_FLAGS_BITS-1:0] flags;
   } Op_st;

   localparam logic [OP_CMD_BITS-1:0] CMD_G01 = 8'h01;
   localparam logic [OP_CMD_BITS-1:0] CMD_G03 = 8'h03;
endpackage

module op_serializer
   import op_serializer_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clk_en,
   input  Op_st                     op_in,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     zero,
   output logic [OP_CMD_BITS-1:0]   cmd,
   output logic [OP_ARG_BITS-1:0]   arg,
   output logic [OP_FLAGS_BITS-1:0] flags,
   output logic                     set_cmd,
   output logic                     set_flags,
   output logic                     set_arg_1,
   output logic                     set_arg_2,
   output logic                     set_arg_3,
   output logic                     set_arg_4,
   output logic                     busy,
   output logic                     done
);

   typedef enum logic [2:0] {IDLE, ZERO, HDR, A1, A2, A3, A4} state_t;

   state_t state, state_nx;
   Op_st   op_q;
   logic   done_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         op_q   <= '0;
         done_q <= 1'b0;
      end else if (clk_en) begin
         state  <= state_nx;
         if (state == IDLE && in_valid)
            op_q <= op_in;
         done_q <= (state != IDLE) && (state_nx == IDLE);
      end
   end

`ifdef OP_SERIALIZER_SKIP_ZERO_ARGS_EN
   logic [3:0] nz, rem;

   always_comb begin
      nz = {op_q.arg_4 != '0, op_q.arg_3 != '0, op_q.arg_2 != '0, op_q.arg_1 != '0};
      rem = 4'b0000;
      state_nx = state;
      case (state)
         IDLE:    state_nx = in_valid ? ZERO : IDLE;
         ZERO:    state_nx = HDR;
         default: begin
            // Remaining candidate args strictly after the current state.
            case (state)
               HDR:     rem = nz;
               A1:      rem = nz & 4'b1110;
               A2:      rem = nz & 4'b1100;
               A3:      rem = nz & 4'b1000;
               default: rem = 4'b0000;
            endcase
            if      (rem[0]) state_nx = A1;
            else if (rem[1]) state_nx = A2;
            else if (rem[2]) state_nx = A3;
            else if (rem[3]) state_nx = A4;
            else             state_nx = IDLE;
         end
      endcase
   end
`else
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = in_valid ? ZERO : IDLE;
         ZERO:    state_nx = HDR;
         HDR:     state_nx = A1;
         A1:      state_nx = A2;
         A2:      state_nx = A3;
         A3:      state_nx = A4;
         default: state_nx = IDLE;
      endcase
   end
`endif

   // Moore decode: nothing here looks at in_valid or op_in.
   always_comb begin
      zero      = 1'b0;
      set_cmd   = 1'b0;
      set_flags = 1'b0;
      set_arg_1 = 1'b0;
      set_arg_2 = 1'b0;
      set_arg_3 = 1'b0;
      set_arg_4 = 1'b0;
      arg       = '0;
      case (state)
         ZERO: zero = 1'b1;
         HDR: begin
            set_cmd   = 1'b1;
            set_flags = 1'b1;
         end
         A1: begin set_arg_1 = 1'b1; arg = op_q.arg_1; end
         A2: begin set_arg_2 = 1'b1; arg = op_q.arg_2; end
         A3: begin set_arg_3 = 1'b1; arg = op_q.arg_3; end
         A4: begin set_arg_4 = 1'b1; arg = op_q.arg_4; end
         default: ;
      endcase
   end

   assign cmd      = op_q.cmd;
   assign flags    = op_q.flags;
   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);
   assign done     = done_q;

endmodule

// File: tb/tb_op_serializer.sv
// Scoreboard bench for op_serializer: stimulus pushes per-cycle expected outputs, a monitor pops and compares.
// Cycle numbers below follow the "cycle n ends at edge n" convention; spec cycle = cyc + 1.

module tb_op_serializer;
   import op_serializer_pkg::*;

   logic clk = 1'b0, reset = 1'b1, clk_en = 1'b1, in_valid = 1'b0;
   Op_st op_in = '0;
   logic in_ready, zero, set_cmd, set_flags, set_arg_1, set_arg_2, set_arg_3, set_arg_4, busy, done;
   logic [OP_CMD_BITS-1:0]   cmd;
   logic [OP_ARG_BITS-1:0]   arg;
   logic [OP_FLAGS_BITS-1:0] flags;

   op_serializer dut (
      .clk(clk), .reset(reset), .clk_en(clk_en), .op_in(op_in), .in_valid(in_valid),
      .in_ready(in_ready), .zero(zero), .cmd(cmd), .arg(arg), .flags(flags),
      .set_cmd(set_cmd), .set_flags(set_flags), .set_arg_1(set_arg_1), .set_arg_2(set_arg_2),
      .set_arg_3(set_arg_3), .set_arg_4(set_arg_4), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic zero, set_cmd, set_flags;
      logic [3:0] set_arg;
      logic done, busy, in_ready;
      logic [7:0]  cmd;
      logic [15:0] arg;
      logic [3:0]  flags;
   } obs_t;

   typedef struct {
      int   cyc;
      obs_t o;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   n_cmp = 0, n_bad = 0;
   logic fin_req = 1'b0;

   function automatic obs_t snap();
      obs_t o;
      o.zero = zero; o.set_cmd = set_cmd; o.set_flags = set_flags;
      o.set_arg = {set_arg_4, set_arg_3, set_arg_2, set_arg_1};
      o.done = done; o.busy = busy; o.in_ready = in_ready;
      o.cmd = cmd; o.arg = arg; o.flags = flags;
      return o;
   endfunction

   function automatic logic [15:0] argn(Op_st op, int n);
      case (n)
         1:       return op.arg_1;
         2:       return op.arg_2;
         3:       return op.arg_3;
         default: return op.arg_4;
      endcase
   endfunction

   function automatic obs_t rst_obs();
      obs_t o = '0;
      o.in_ready = 1'b1;
      return o;
   endfunction

   // k: 0 ZERO, 1 HDR, 2..5 A1..A4, 6 done cycle
   function automatic obs_t exp_obs(int k, Op_st op);
      obs_t o = '0;
      o.cmd   = op.cmd;
      o.flags = op.flags;
      o.busy  = (k != 6);
      o.in_ready = (k == 6);
      case (k)
         0: o.zero = 1'b1;
         1: begin o.set_cmd = 1'b1; o.set_flags = 1'b1; end
         6: o.done = 1'b1;
         default: begin
            o.set_arg[k-2] = 1'b1;
            o.arg = argn(op, k - 1);
         end
      endcase
      return o;
   endfunction

   task automatic push(int spec_cyc, obs_t o);
      exp_t x;
      x.cyc = spec_cyc - 1;
      x.o   = o;
      q.push_back(x);
   endtask

   task automatic push_seq(Op_st op, int e_edge, int stall_k, int stall_n, int upto);
      int t = e_edge + 1;
      for (int k = 0; k < upto; k++) begin
`ifdef OP_SERIALIZER_SKIP_ZERO_ARGS_EN
         if (k >= 2 && k <= 5 && argn(op, k - 1) == 16'd0) continue;
`endif
         for (int r = 0; r <= ((k == stall_k) ? stall_n : 0); r++) begin
            push(t, exp_obs(k, op));
            t++;
         end
      end
   endtask

   task automatic wait_to(int spec_cyc);
      while (cyc + 1 < spec_cyc) @(negedge clk);
   endtask

   // Called at a negedge in an idle cycle; returns the accept edge index.
   task automatic send_op(Op_st op, int stall_k, int stall_n, int upto, logic hold, output int e_edge);
      e_edge   = cyc + 1;
      in_valid = 1'b1;
      op_in    = op;
      push_seq(op, e_edge, stall_k, stall_n, upto);
      @(negedge clk);
      if (!hold) begin
         in_valid = 1'b0;
         op_in    = '1;
      end
   endtask

   // Monitor: compares scheduled expectations and flags any unscheduled strobe or done.
   always @(negedge clk) begin
      while (q.size() != 0 && q[0].cyc < cyc) begin
         e = q.pop_front();
         n_cmp++; n_bad++;
         $display("FAIL missed cyc %0d: got nothing want %h", e.cyc + 1, e.o);
      end
      if (q.size() != 0 && q[0].cyc == cyc) begin
         e = q.pop_front();
         n_cmp++;
         if (snap() !== e.o) begin
            n_bad++;
            $display("FAIL outputs cyc %0d: got %h want %h", cyc + 1, snap(), e.o);
         end
      end else if (zero | set_cmd | set_flags | set_arg_1 | set_arg_2 | set_arg_3 | set_arg_4 | done) begin
         n_cmp++; n_bad++;
         $display("FAIL unexpected cyc %0d: got %h want no strobe", cyc + 1, snap());
      end
      if (fin_req && q.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL leftover: got %0d pending want 0", q.size());
         q.delete();
      end
   end

   Op_st op1, op2, op_sk, op4;
   int   ee;

   initial begin
      op1   = '{cmd: CMD_G03, arg_1: 16'd1, arg_2: 16'd2, arg_3: 16'd3, arg_4: 16'd4, flags: 4'd3};
      op2   = '{cmd: CMD_G01, arg_1: 16'd5, arg_2: 16'd5, arg_3: 16'd0, arg_4: 16'd0, flags: 4'd0};
      op4   = '{cmd: CMD_G01, arg_1: 16'd9, arg_2: 16'd8, arg_3: 16'd7, arg_4: 16'd6, flags: 4'd1};
      op_sk = '{cmd: CMD_G01, arg_1: 16'd0, arg_2: 16'd7, arg_3: 16'd0, arg_4: 16'd0, flags: 4'd0};

      repeat (2) @(negedge clk);
      reset = 1'b0;
      push(cyc + 2, rst_obs());
      push(cyc + 3, rst_obs());
      repeat (2) @(negedge clk);

      // Single op, full sequence
      send_op(op1, -1, 0, 7, 1'b0, ee);
      wait_to(ee + 7);

      // Back-to-back: second op accepted on the edge ending the done cycle
      send_op(op1, -1, 0, 7, 1'b1, ee);
      op_in = op2;
      push_seq(op2, ee + 7, -1, 0, 7);
      wait_to(ee + 8);
      in_valid = 1'b0;
      wait_to(ee + 14);
      @(negedge clk);

      // clk_en low for 3 cycles while in A2
      send_op(op1, 3, 3, 7, 1'b0, ee);
      wait_to(ee + 4);
      clk_en = 1'b0;
      wait_to(ee + 7);
      clk_en = 1'b1;
      wait_to(ee + 11);

      // Reset in HDR abandons the op
      send_op(op1, -1, 0, 2, 1'b0, ee);
      wait_to(ee + 2);
      reset = 1'b1;
      push(ee + 3, rst_obs());
      push(ee + 4, rst_obs());
      wait_to(ee + 3);
      reset = 1'b0;
      wait_to(ee + 5);

      send_op(op4, -1, 0, 7, 1'b0, ee);
      wait_to(ee + 8);

      // Zero args: skipped when the skip feature is built in
      send_op(op_sk, -1, 0, 7, 1'b0, ee);
      wait_to(ee + 10);

      fin_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
